spart_driver: RTL and testbench



---
 rtl/spart_pkg.sv | 34 +++
 rtl/spart_div_lut.sv | 23 ++
 rtl/spart_driver.sv | 175 +++++++++++++++++
 tb/tb_spart_driver.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared constants and types for the SPART bus-master driver.
package spart_pkg;

  // SPART register map seen on ioaddr
  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBLO = 2'b10;
  localparam logic [1:0] ADDR_DBHI = 2'b11;

  // Supported baud rates, indexed by br_cfg
  localparam int unsigned BAUD_4800  = 4800;
  localparam int unsigned BAUD_9600  = 9600;
  localparam int unsigned BAUD_19200 = 19200;
  localparam int unsigned BAUD_38400 = 38400;

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    GAP,
    IDLE,
    RX_RD,
    TX_WR
  } state_t;

  // Divisor for a 16x oversampling baud generator
  function automatic logic [DIV_W-1:0] calc_div(input int unsigned clk_freq,
                                                input int unsigned baud);
    return DIV_W'(clk_freq / (16 * baud) - 1);
  endfunction

endpackage

// File: rtl/spart_div_lut.sv
// Maps the 2-bit baud select to the 16-bit SPART divisor for a given clock.
module spart_div_lut
  import spart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000
) (
  input  logic [1:0]  br_cfg,
  output logic [15:0] div
);

  // Constant-folded divisor selection
  always_comb begin
    div = calc_div(CLK_FREQ, BAUD_4800);
    unique case (br_cfg)
      2'b00:   div = calc_div(CLK_FREQ, BAUD_4800);
      2'b01:   div = calc_div(CLK_FREQ, BAUD_9600);
      2'b10:   div = calc_div(CLK_FREQ, BAUD_19200);
      2'b11:   div = calc_div(CLK_FREQ, BAUD_38400);
      default: div = calc_div(CLK_FREQ, BAUD_4800);
    endcase
  end

endmodule

// File: rtl/spart_driver.sv
// Bus master for the SPART processor interface: programs the divisor, drains
// received bytes and issues client transmit bytes, one access then one GAP.
module spart_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       tx_req,
  input  logic [7:0] tx_byte,
  output logic       tx_ack,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       cfg_done,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rda,
  input  logic       tbr
);

  state_t      state, state_d;
  logic        gap_to_hi, gap_to_hi_d;
  logic        take_cfg;
  logic [1:0]  cfg_q;
  logic        cfg_pending;
  logic [15:0] div;

  logic             drv_en, drv_en_d;
  logic [BYTE_W-1:0] drv_data, drv_data_d;
  logic             iocs_d, iorw_d, tx_ack_d, cfg_done_d;
  logic [1:0]       ioaddr_d;

  spart_div_lut #(.CLK_FREQ(CLK_FREQ)) u_div_lut (
    .br_cfg (cfg_q),
    .div    (div)
  );

  // Write data is only placed on the bus during write accesses
  assign databus = drv_en ? drv_data : 8'hzz;

  // State and GAP-return register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CFG_LO;
      gap_to_hi <= 1'b0;
    end else begin
      state     <= state_d;
      gap_to_hi <= gap_to_hi_d;
    end
  end

  // Next state plus decode of the bus cycle that the next state performs
  always_comb begin
    state_d     = state;
    gap_to_hi_d = gap_to_hi;
    take_cfg    = 1'b0;
    iocs_d      = 1'b0;
    iorw_d      = 1'b1;
    ioaddr_d    = ADDR_BUF;
    drv_en_d    = 1'b0;
    drv_data_d  = 8'h00;
    tx_ack_d    = 1'b0;
    cfg_done_d  = cfg_done;

    unique case (state)
      // Leaving reset the write has not been issued yet (iocs low), so stay once
      CFG_LO: begin
        if (iocs) begin
          state_d     = GAP;
          gap_to_hi_d = 1'b1;
        end
      end
      CFG_HI: begin
        state_d     = GAP;
        gap_to_hi_d = 1'b0;
      end
      GAP: state_d = gap_to_hi ? CFG_HI : IDLE;
      IDLE: begin
        if (cfg_pending) begin
          state_d  = CFG_LO;
          take_cfg = 1'b1;
        end else if (rda) begin
          state_d = RX_RD;
        end else if (tx_req && tbr && cfg_done) begin
          state_d = TX_WR;
        end
      end
      RX_RD, TX_WR: begin
        state_d     = GAP;
        gap_to_hi_d = 1'b0;
      end
      default: state_d = CFG_LO;
    endcase

    unique case (state_d)
      CFG_LO: begin
        iocs_d     = 1'b1;
        iorw_d     = 1'b0;
        ioaddr_d   = ADDR_DBLO;
        drv_en_d   = 1'b1;
        drv_data_d = div[7:0];
        cfg_done_d = 1'b0;
      end
      CFG_HI: begin
        iocs_d     = 1'b1;
        iorw_d     = 1'b0;
        ioaddr_d   = ADDR_DBHI;
        drv_en_d   = 1'b1;
        drv_data_d = div[15:8];
      end
      RX_RD: iocs_d = 1'b1;
      TX_WR: begin
        iocs_d     = 1'b1;
        iorw_d     = 1'b0;
        drv_en_d   = 1'b1;
        drv_data_d = tx_byte;
        tx_ack_d   = 1'b1;
      end
      IDLE:    cfg_done_d = 1'b1;
      default: ;
    endcase
  end

  // Registered bus and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      iocs     <= 1'b0;
      iorw     <= 1'b1;
      ioaddr   <= ADDR_BUF;
      drv_en   <= 1'b0;
      drv_data <= 8'h00;
      tx_ack   <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      iocs     <= iocs_d;
      iorw     <= iorw_d;
      ioaddr   <= ioaddr_d;
      drv_en   <= drv_en_d;
      drv_data <= drv_data_d;
      tx_ack   <= tx_ack_d;
      cfg_done <= cfg_done_d;
    end
  end

  // Capture the read byte at the end of the read cycle, flag it during GAP
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid <= 1'b0;
      rx_byte  <= 8'h00;
    end else begin
      rx_valid <= (state == RX_RD);
      if (state == RX_RD) begin
        rx_byte <= databus;
      end
    end
  end

  // Track baud select; a change is queued until the FSM is back in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q       <= br_cfg;
      cfg_pending <= 1'b0;
    end else if (br_cfg != cfg_q) begin
      cfg_q       <= br_cfg;
      cfg_pending <= 1'b1;
    end else if (take_cfg) begin
      cfg_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_driver.sv
// Self-checking bench for spart_driver: a queue-based bus-cycle predictor
// driven by directed scenarios and a randomized client/SPART environment.
module tb_spart_driver;

  localparam int unsigned CLK_FREQ = 100_000_000;

  logic       clk = 1'b0;
  logic       rst, tx_req, rda, tbr;
  logic [1:0] br_cfg;
  logic [7:0] tx_byte;
  logic       tx_ack, rx_valid, cfg_done, iocs, iorw;
  logic [7:0] rx_byte;
  logic [1:0] ioaddr;
  wire  [7:0] databus;

  // SPART side: holds one received byte and drives it on a buffer read
  logic       sp_has, sp_load;
  logic [7:0] sp_val, sp_load_val;
  assign databus = (iocs === 1'b1 && iorw === 1'b1 && ioaddr === 2'b00) ? sp_val : 8'hzz;

  always #5 clk = ~clk;

  spart_driver #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .tx_req   (tx_req),
    .tx_byte  (tx_byte),
    .tx_ack   (tx_ack),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .cfg_done (cfg_done),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .rda      (rda),
    .tbr      (tbr)
  );

  // One expected bus cycle
  typedef struct packed {
    logic       cs;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
    logic       ack;
    logic       rxv;
    logic       done;
    logic       dec;
    logic       rs;
  } exp_t;

  exp_t       mq[$];
  logic [7:0] txq[$];
  int         total = 0, bad = 0, ncyc = 0;
  logic [1:0] m_cfg;
  logic       m_pend, prev_rst, want_rst, tbr_want, rand_en;
  logic       br_req, rst_on_hi, done_prev;
  logic [1:0] br_next;
  logic [7:0] m_rx;
  int         rd_cyc, ack_cyc, ack_cnt, done_rise, rel_cyc;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", tag, ncyc, got, want);
    end
  endtask

  function automatic logic [15:0] ref_div(input logic [1:0] sel);
    int unsigned baud;
    baud = 4800 << sel;
    return 16'(CLK_FREQ / (16 * baud) - 1);
  endfunction

  function automatic exp_t mk(input logic cs, input logic rw, input logic [1:0] addr,
                              input logic [7:0] data, input logic ack, input logic rxv,
                              input logic done, input logic dec, input logic rs);
    exp_t e;
    e.cs = cs; e.rw = rw; e.addr = addr; e.data = data; e.ack = ack;
    e.rxv = rxv; e.done = done; e.dec = dec; e.rs = rs;
    return e;
  endfunction

  function automatic void push_dec();
    mq.push_back(mk(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
  endfunction

  function automatic void push_cfg(input logic [1:0] sel);
    logic [15:0] d;
    d = ref_div(sel);
    mq.push_back(mk(1'b1, 1'b0, 2'b10, d[7:0],  1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    mq.push_back(mk(1'b0, 1'b1, 2'b00, 8'h00,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    mq.push_back(mk(1'b1, 1'b0, 2'b11, d[15:8], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    mq.push_back(mk(1'b0, 1'b1, 2'b00, 8'h00,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    push_dec();
  endfunction

  // One clock: check this cycle, update environment inputs, advance predictor
  task automatic tick();
    exp_t e;
    logic was_read, took;
    @(negedge clk);
    ncyc++;
    if (mq.size() == 0) begin
      chk("model_queue", 16'd0, 16'd1);
      e = mk(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end else begin
      e = mq.pop_front();
    end
    if (e.rs)  m_rx = 8'h00;
    if (e.rxv) m_rx = e.data;

    chk("iocs",     16'(iocs),     16'(e.cs));
    chk("iorw",     16'(iorw),     16'(e.rw));
    chk("ioaddr",   16'(ioaddr),   16'(e.addr));
    chk("tx_ack",   16'(tx_ack),   16'(e.ack));
    chk("rx_valid", 16'(rx_valid), 16'(e.rxv));
    chk("cfg_done", 16'(cfg_done), 16'(e.done));
    chk("rx_byte",  16'(rx_byte),  16'(m_rx));
    if (e.cs) chk("databus",   {8'h00, databus}, {8'h00, e.data});
    else      chk("databus_z", {8'h00, databus}, {8'h00, 8'hzz});

    if (iocs === 1'b1 && iorw === 1'b1) rd_cyc = ncyc;
    if (tx_ack === 1'b1) begin ack_cyc = ncyc; ack_cnt++; end
    if (cfg_done === 1'b1 && !done_prev) done_rise = ncyc;
    done_prev = (cfg_done === 1'b1);

    // environment reacts to this cycle's bus activity
    was_read = (iocs === 1'b1 && iorw === 1'b1 && ioaddr === 2'b00);
    if (was_read) sp_has = 1'b0;
    if (tx_ack === 1'b1 && txq.size() != 0) void'(txq.pop_front());
    if (rand_en) begin
      if (!sp_has && !was_read && $urandom_range(0, 4) == 0) begin
        sp_has = 1'b1;
        sp_val = 8'($urandom);
      end
      if (txq.size() < 2 && $urandom_range(0, 3) == 0) txq.push_back(8'($urandom));
      tbr_want = ($urandom_range(0, 3) != 0);
    end
    if (sp_load && !sp_has && !was_read) begin
      sp_has  = 1'b1;
      sp_val  = sp_load_val;
      sp_load = 1'b0;
    end
    if (rst_on_hi && iocs === 1'b1 && ioaddr === 2'b11) begin
      want_rst  = 1'b1;
      rst_on_hi = 1'b0;
    end
    if (br_req && e.cs && e.addr == 2'b00) begin
      br_cfg = br_next;
      br_req = 1'b0;
    end
    rda     = sp_has;
    tbr     = tbr_want;
    tx_req  = (txq.size() != 0);
    tx_byte = tx_req ? txq[0] : 8'h00;
    rst     = want_rst;

    // predictor for the following cycles
    took = 1'b0;
    if (rst) begin
      mq.delete();
      mq.push_back(mk(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      m_cfg    = br_cfg;
      m_pend   = 1'b0;
      prev_rst = 1'b1;
    end else begin
      if (prev_rst) begin
        push_cfg(m_cfg);
      end else if (e.dec) begin
        if (m_pend) begin
          push_cfg(m_cfg);
          took = 1'b1;
        end else if (rda) begin
          mq.push_back(mk(1'b1, 1'b1, 2'b00, sp_val, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
          mq.push_back(mk(1'b0, 1'b1, 2'b00, sp_val, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
          push_dec();
        end else if (tx_req && tbr) begin
          mq.push_back(mk(1'b1, 1'b0, 2'b00, tx_byte, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
          mq.push_back(mk(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
          push_dec();
        end else begin
          push_dec();
        end
      end
      if (br_cfg != m_cfg) begin
        m_cfg  = br_cfg;
        m_pend = 1'b1;
      end else if (took) begin
        m_pend = 1'b0;
      end
      prev_rst = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog cycle=%0d", ncyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b1; want_rst = 1'b1; br_cfg = 2'b01; tx_req = 1'b0; tx_byte = 8'h00;
    rda = 1'b0; tbr = 1'b0; tbr_want = 1'b0; rand_en = 1'b0;
    sp_has = 1'b0; sp_val = 8'h00; sp_load = 1'b0; sp_load_val = 8'h00;
    br_req = 1'b0; br_next = 2'b00; rst_on_hi = 1'b0; done_prev = 1'b0;
    m_cfg = br_cfg; m_pend = 1'b0; prev_rst = 1'b1; m_rx = 8'h00;
    rd_cyc = 0; ack_cyc = 0; ack_cnt = 0; done_rise = 0; rel_cyc = 0;
    mq.push_back(mk(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));

    // reset held two edges with br_cfg=01, then configuration and quiet idle
    tick();
    want_rst = 1'b0;
    tick();
    rel_cyc = ncyc;
    run(10);
    chk("cfg_done_latency", 16'(done_rise - rel_cyc), 16'd5);

    // single transmit, client drops request on ack
    tbr_want = 1'b1;
    ack_cnt  = 0;
    txq.push_back(8'h41);
    run(8);
    chk("tx_single_ack", 16'(ack_cnt), 16'd1);

    // single receive of 0x5A
    sp_load = 1'b1; sp_load_val = 8'h5A;
    run(8);
    chk("rx_byte_5a", 16'(rx_byte), 16'h005A);

    // simultaneous receive and transmit: read first, write three cycles later
    sp_load = 1'b1; sp_load_val = 8'hC3;
    txq.push_back(8'h33);
    run(10);
    chk("rx_then_tx", 16'(ack_cyc - rd_cyc), 16'd3);

    // baud change 01->11 during a write, then reprogramming to 0x00A1
    br_next = 2'b11; br_req = 1'b1;
    txq.push_back(8'h77);
    run(14);
    chk("br_applied", 16'(br_req), 16'd0);

    // change to 00 during a write, reset during the DB-high write
    br_next = 2'b00; br_req = 1'b1;
    txq.push_back(8'h5C);
    rst_on_hi = 1'b1;
    for (int i = 0; i < 30 && rst_on_hi; i++) tick();
    chk("reset_on_hi_seen", 16'(rst_on_hi), 16'd0);
    want_rst = 1'b0;
    run(10);

    // randomized traffic with occasional baud changes and one reset
    rand_en = 1'b1;
    for (int i = 1; i <= 1500; i++) begin
      if (i % 250 == 0) begin
        br_next = 2'($urandom);
        br_req  = 1'b1;
      end
      if (i == 777) want_rst = 1'b1;
      if (i == 779) want_rst = 1'b0;
      tick();
    end

    // drain everything still outstanding
    rand_en  = 1'b0;
    tbr_want = 1'b1;
    run(40);
    chk("drain_tx", 16'(txq.size()), 16'd0);
    chk("drain_rx", 16'(sp_has), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
